// File: rtl/ysyx_22051013_regfile_sb.sv
// Multi-port register file with per-register busy/tag scoreboard and same-cycle writeback bypass.
// Reads are combinational (0 cycles); state and busy_cnt update on the rising edge; no backpressure, stale writebacks are dropped.
module ysyx_22051013_regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRP  = 3,
    parameter int NWP  = 2,
    parameter int TW   = 4,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    input  logic [TW-1:0]       issue_tag,
    input  logic [NWP-1:0]      wb_valid,
    input  logic [NWP*AW-1:0]   wb_addr,
    input  logic [NWP*TW-1:0]   wb_tag,
    input  logic [NWP*XLEN-1:0] wb_data,
    input  logic                flush,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_ready,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [TW-1:0]   tag  [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic [NWP-1:0]  wb_acc;
    logic [NWP-1:0]  wb_clr;
    logic [AW-1:0]   wa;
    logic [AW-1:0]   ra;
    logic            issue_go;

    assign issue_go = issue_valid && !flush && (issue_rd != '0);

    // A writeback is accepted if the target is idle or the tag names the current producer.
    always_comb begin
        wb_acc = '0;
        wb_clr = '0;
        wa     = '0;
        for (int k = 0; k < NWP; k++) begin
            wa = wb_addr[k*AW +: AW];
            if (wb_valid[k] && (wa != '0) &&
                (!busy[wa] || (wb_tag[k*TW +: TW] == tag[wa]))) begin
                wb_acc[k] = 1'b1;
            end
            wb_clr[k] = wb_acc[k] && busy[wa];
        end
    end

    // Issue is applied after writeback clears so a same-cycle claim keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWP; k++) begin
            if (wb_clr[k]) begin
                busy_nxt[wb_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_go) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tag[i]  <= '0;
            end
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (issue_go) begin
                tag[issue_rd] <= issue_tag;
            end
            // Later ports overwrite earlier ones, so the highest accepted index wins.
            for (int k = 0; k < NWP; k++) begin
                if (wb_acc[k]) begin
                    regs[wb_addr[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        ra       = '0;
        for (int j = 0; j < NRP; j++) begin
            ra = rd_addr[j*AW +: AW];
            rd_data[j*XLEN +: XLEN] = regs[ra];
            rd_ready[j]             = !busy[ra];
            for (int k = 0; k < NWP; k++) begin
                if (wb_acc[k] && (wb_addr[k*AW +: AW] == ra)) begin
                    rd_data[j*XLEN +: XLEN] = wb_data[k*XLEN +: XLEN];
                    rd_ready[j]             = 1'b1;
                end
            end
            if (ra == '0) begin
                rd_data[j*XLEN +: XLEN] = '0;
                rd_ready[j]             = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22051013_regfile_sb.sv
// Directed-vector bench for the scoreboarded register file.
module tb_ysyx_22051013_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRP  = 3;
    localparam int NWP  = 2;
    localparam int TW   = 4;
    localparam int AW   = 5;

    logic                clk;
    logic                rst;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic [TW-1:0]       issue_tag;
    logic [NWP-1:0]      wb_valid;
    logic [NWP*AW-1:0]   wb_addr;
    logic [NWP*TW-1:0]   wb_tag;
    logic [NWP*XLEN-1:0] wb_data;
    logic                flush;
    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_ready;
    logic [AW:0]         busy_cnt;

    int checks;
    int failures;

    ysyx_22051013_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush(flush), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] rdat(input int j);
        return rd_data[j*XLEN +: XLEN];
    endfunction

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_tag   = '0;
        wb_valid    = '0;
        wb_addr     = '0;
        wb_tag      = '0;
        wb_data     = '0;
        flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic wb(input int k, input int a, input int t, input logic [XLEN-1:0] d);
        wb_valid[k]           = 1'b1;
        wb_addr[k*AW +: AW]   = AW'(a);
        wb_tag[k*TW +: TW]    = TW'(t);
        wb_data[k*XLEN +: XLEN] = d;
    endtask

    task automatic issue(input int a, input int t);
        issue_valid = 1'b1;
        issue_rd    = AW'(a);
        issue_tag   = TW'(t);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        rd_addr = '0;
        #3;
        for (int a = 0; a < NREG; a++) begin
            rd_addr = {NRP{AW'(a)}};
            #1;
            for (int j = 0; j < NRP; j++) begin
                checks++;
                if (rdat(j) !== 64'd0 || rd_ready[j] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_read a=%0d port=%0d got data=%h rdy=%b want 0/1", a, j, rdat(j), rd_ready[j]);
                end
            end
        end
        checks++;
        if (busy_cnt !== 6'd0) begin
            failures++;
            $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_issue_wb();
        issue(5, 3);
        rd_addr = {NRP{AW'(5)}};
        #1;
        checks++;
        if (rd_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL issue_same_cycle_ready got %b want 1", rd_ready[0]);
        end
        tick();
        rd_addr = {NRP{AW'(5)}};
        #1;
        checks++;
        if (rd_ready[0] !== 1'b0 || busy_cnt !== 6'd1) begin
            failures++;
            $display("FAIL issue_busy got rdy=%b cnt=%0d want 0/1", rd_ready[0], busy_cnt);
        end
        wb(0, 5, 3, 64'hDEAD);
        #1;
        checks++;
        if (rdat(0) !== 64'hDEAD || rd_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL wb_bypass got data=%h rdy=%b want dead/1", rdat(0), rd_ready[0]);
        end
        tick();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rdat(1) !== 64'hDEAD || rd_ready[1] !== 1'b1) begin
            failures++;
            $display("FAIL wb_commit got cnt=%0d data=%h rdy=%b want 0/dead/1", busy_cnt, rdat(1), rd_ready[1]);
        end
    endtask

    task automatic test_stale_tag();
        issue(7, 1);
        tick();
        issue(7, 2);
        tick();
        rd_addr = {NRP{AW'(7)}};
        wb(1, 7, 1, 64'h11);
        #1;
        checks++;
        if (rd_ready[1] !== 1'b0 || rdat(1) !== 64'd0) begin
            failures++;
            $display("FAIL stale_bypass got data=%h rdy=%b want 0/0", rdat(1), rd_ready[1]);
        end
        tick();
        #1;
        checks++;
        if (rd_ready[1] !== 1'b0 || rdat(1) !== 64'd0 || busy_cnt !== 6'd1) begin
            failures++;
            $display("FAIL stale_dropped got data=%h rdy=%b cnt=%0d want 0/0/1", rdat(1), rd_ready[1], busy_cnt);
        end
        wb(1, 7, 2, 64'h22);
        #1;
        checks++;
        if (rd_ready[2] !== 1'b1 || rdat(2) !== 64'h22) begin
            failures++;
            $display("FAIL match_bypass got data=%h rdy=%b want 22/1", rdat(2), rd_ready[2]);
        end
        tick();
        #1;
        checks++;
        if (rd_ready[0] !== 1'b1 || rdat(0) !== 64'h22 || busy_cnt !== 6'd0) begin
            failures++;
            $display("FAIL match_commit got data=%h rdy=%b cnt=%0d want 22/1/0", rdat(0), rd_ready[0], busy_cnt);
        end
    endtask

    task automatic test_same_addr();
        rd_addr = {NRP{AW'(9)}};
        wb(0, 9, 0, 64'hA);
        wb(1, 9, 0, 64'hB);
        #1;
        checks++;
        if (rdat(2) !== 64'hB || rd_ready[2] !== 1'b1) begin
            failures++;
            $display("FAIL dual_wb_bypass got data=%h rdy=%b want b/1", rdat(2), rd_ready[2]);
        end
        tick();
        #1;
        checks++;
        if (rdat(0) !== 64'hB) begin
            failures++;
            $display("FAIL dual_wb_commit got %h want b", rdat(0));
        end
        rd_addr = '0;
        wb(0, 0, 0, 64'hFF);
        issue(0, 5);
        #1;
        checks++;
        if (rdat(0) !== 64'd0 || rd_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL r0_bypass got data=%h rdy=%b want 0/1", rdat(0), rd_ready[0]);
        end
        tick();
        #1;
        checks++;
        if (rdat(1) !== 64'd0 || rd_ready[1] !== 1'b1 || busy_cnt !== 6'd0) begin
            failures++;
            $display("FAIL r0_commit got data=%h rdy=%b cnt=%0d want 0/1/0", rdat(1), rd_ready[1], busy_cnt);
        end
    endtask

    task automatic test_issue_wb_conflict();
        issue(4, 5);
        tick();
        rd_addr = {NRP{AW'(4)}};
        issue(4, 6);
        wb(0, 4, 5, 64'h44);
        #1;
        checks++;
        if (rdat(0) !== 64'h44 || rd_ready[0] !== 1'b1 || busy_cnt !== 6'd1) begin
            failures++;
            $display("FAIL conflict_bypass got data=%h rdy=%b cnt=%0d want 44/1/1", rdat(0), rd_ready[0], busy_cnt);
        end
        tick();
        #1;
        checks++;
        if (rdat(0) !== 64'h44 || rd_ready[0] !== 1'b0 || busy_cnt !== 6'd1) begin
            failures++;
            $display("FAIL conflict_commit got data=%h rdy=%b cnt=%0d want 44/0/1", rdat(0), rd_ready[0], busy_cnt);
        end
        wb(0, 4, 5, 64'h55);
        tick();
        #1;
        checks++;
        if (rdat(0) !== 64'h44 || rd_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL conflict_old_tag got data=%h rdy=%b want 44/0", rdat(0), rd_ready[0]);
        end
        wb(1, 4, 6, 64'h66);
        tick();
        #1;
        checks++;
        if (rdat(0) !== 64'h66 || rd_ready[0] !== 1'b1 || busy_cnt !== 6'd0) begin
            failures++;
            $display("FAIL conflict_new_tag got data=%h rdy=%b cnt=%0d want 66/1/0", rdat(0), rd_ready[0], busy_cnt);
        end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            issue(r, r);
            tick();
        end
        #1;
        checks++;
        if (busy_cnt !== 6'd3) begin
            failures++;
            $display("FAIL pre_flush_cnt got %0d want 3", busy_cnt);
        end
        flush = 1'b1;
        issue(8, 2);
        wb(0, 3, 3, 64'h33);
        tick();
        rd_addr = {AW'(8), AW'(2), AW'(1)};
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rd_ready !== 3'b111) begin
            failures++;
            $display("FAIL flush_clear got cnt=%0d rdy=%b want 0/111", busy_cnt, rd_ready);
        end
        rd_addr = {NRP{AW'(3)}};
        #1;
        checks++;
        if (rdat(0) !== 64'h33 || rd_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL flush_wb_store got data=%h rdy=%b want 33/1", rdat(0), rd_ready[0]);
        end
    endtask

    task automatic test_async_reset();
        issue(10, 1);
        tick();
        rd_addr = {AW'(10), AW'(9), AW'(5)};
        #1;
        checks++;
        if (busy_cnt !== 6'd1 || rd_ready[2] !== 1'b0 || rdat(1) !== 64'hB || rdat(0) !== 64'hDEAD) begin
            failures++;
            $display("FAIL pre_reset got cnt=%0d rdy=%b d9=%h d5=%h want 1/0xx/b/dead", busy_cnt, rd_ready, rdat(1), rdat(0));
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rd_ready !== 3'b111 || rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d rdy=%b data=%h want 0/111/0", busy_cnt, rd_ready, rd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        #1;
        checks++;
        if (busy_cnt !== 6'd0 || rd_ready !== 3'b111 || rdat(0) !== 64'd0) begin
            failures++;
            $display("FAIL post_reset got cnt=%0d rdy=%b data=%h want 0/111/0", busy_cnt, rd_ready, rdat(0));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_issue_wb();
        test_stale_tag();
        test_same_addr();
        test_issue_wb_conflict();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22051013_regfile_sb.md
# ysyx_22051013_regfile_sb

Parametrised multi-port integer register file with a per-register scoreboard, for the out-of-order-writeback pipeline. It holds the NREG×XLEN architectural registers and a busy bit plus producer tag per register. Reads report data and readiness with same-cycle writeback bypass. It sits between decode/issue, which reads operands and claims destinations, and the writeback stage, which retires results.

## Interface
- XLEN, 64, register width
- NREG, 32, register count (power of two); AW = $clog2(NREG)
- NRP, 3, read ports
- NWP, 2, writeback ports
- TW, 4, producer tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous and active-low
- issue_valid  in  1  claim destination register issue_rd
- issue_rd  in  AW  destination to mark busy
- issue_tag  in  TW  producer tag recorded for issue_rd
- wb_valid  in  NWP  per-port writeback valid
- wb_addr  in  NWP*AW  packed writeback addresses; port k at [k*AW +: AW]
- wb_tag  in  NWP*TW  packed writeback tags
- wb_data  in  NWP*XLEN  packed writeback data
- flush  in  1  clear all busy bits (pipeline squash)
- rd_addr  in  NRP*AW  packed read addresses
- rd_data  out  NRP*XLEN  packed read data, combinational
- rd_ready  out  NRP  operand available this cycle, combinational
- busy_cnt  out  AW+1  registered count of busy registers

## Operation
- State: regs[NREG], busy[NREG], tag[NREG]. Register 0 reads as 0, is never busy, and ignores writes and issues.
- Writeback port k is accepted for address a ≠ 0 when wb_valid[k] and (!busy[a] or wb_tag[k] == tag[a]). The check uses pre-edge state. Non-matching writes to busy registers are stale and dropped entirely.
- An accepted write stores data at the edge. It clears busy[a] when busy[a] is set and the tag matches.
- Multiple accepted writes to the same address in one cycle: highest port index wins the data.
- Issue with issue_rd ≠ 0: sets busy[issue_rd] and tag[issue_rd] ← issue_tag.
  - Issue takes priority over a same-cycle writeback clear to the same register; busy stays set with the new tag.
  - The writeback data is still stored if that write was accepted.
- flush: clears every busy bit and takes priority over issue; issue is ignored that cycle. Writebacks are evaluated against pre-flush state and still store data. Tags are unchanged.
- Read port j with address a:
  - Bypass hit: some port k has wb_valid, wb_addr == a ≠ 0, and the write is accepted. Then rd_data = the highest such k's data and rd_ready = 1.
  - Otherwise rd_data = regs[a] and rd_ready = !busy[a].
  - a == 0: rd_data = 0, rd_ready = 1.
  - Reads reflect pre-edge issue state; a same-cycle issue never affects a same-cycle read.
- busy_cnt is the popcount of busy after the edge update, registered alongside busy.

## Timing
- Reset (rst low, asynchronous): all regs = 0, busy = 0, tag = 0, busy_cnt = 0.
  - Reads during reset return stored values (0) with rd_ready = 1.
  - Deassertion is synchronous to clk at the integration level.
- Write-to-read: 0 cycles via bypass; from the array, the cycle after the edge.
- Issue-to-not-ready: rd_ready drops the cycle after issue_valid.
- Writeback-to-ready: same cycle via bypass; from the array, the next cycle.
- busy_cnt lags busy state by 0 cycles: it is updated on the same edge.
- Reset asserted mid-operation clears all state immediately; pending tags are lost.

## Test plan
- Reset then read all 32 addresses on all NRP ports -> rd_data = 0, rd_ready = 1, busy_cnt = 0.
- Issue rd=5 tag=3; next cycle read 5 -> rd_ready = 0, busy_cnt = 1. Then wb port0 addr=5 tag=3 data=0xDEAD -> same-cycle rd_data = 0xDEAD, rd_ready = 1. Next cycle busy_cnt = 0 and the array holds 0xDEAD.
- Issue rd=7 tag=1, then issue rd=7 tag=2. Wb addr=7 tag=1 data=0x11 -> dropped, rd_ready = 0, regs[7] unchanged. Wb tag=2 data=0x22 -> accepted, regs[7] = 0x22.
- Same cycle: port0 and port1 both write addr=9 to a non-busy register, data 0xA and 0xB -> rd_data = 0xB bypassed, stored 0xB. Write addr=0 data=0xFF -> reads remain 0.
- Same-cycle issue rd=4 tag=6 with accepted wb addr=4 of the old tag -> data stored, busy[4] stays set with tag 6, busy_cnt unchanged.
- Issue 3 registers, then flush together with an issue of rd=8 -> busy_cnt = 0, all rd_ready = 1, register 8 not busy. Assert rst mid-sequence -> all outputs return to reset values asynchronously.
